// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: state encoding,
// register-index width and the canned control-output patterns.
package pipe_ctrl_pkg;

  // Architectural register index width and the hard-wired zero register.
  localparam int unsigned RegIdxW = 5;
  localparam logic [RegIdxW-1:0] ZeroReg = '0;

  // Sequencer states; encodings are fixed so Busy/debug views stay stable.
  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StStallLu = 2'd1,
    StMulti   = 2'd2
  } state_e;

  // Bundle of the pipeline-register write enables and flushes.
  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_write;
    logic idex_flush;
    logic exmem_flush;
  } ctrl_t;

  // Normal flow: every register loads, nothing is squashed.
  localparam ctrl_t CtrlDefault = '{
    pc_write:    1'b1,
    ifid_write:  1'b1,
    ifid_flush:  1'b0,
    idex_write:  1'b1,
    idex_flush:  1'b0,
    exmem_flush: 1'b0
  };

  // While in reset: freeze the front end and bubble every stage.
  localparam ctrl_t CtrlReset = '{
    pc_write:    1'b0,
    ifid_write:  1'b0,
    ifid_flush:  1'b1,
    idex_write:  1'b0,
    idex_flush:  1'b1,
    exmem_flush: 1'b1
  };

  // Taken branch in MEM: fetch the target, squash the three younger stages.
  localparam ctrl_t CtrlBranch = '{
    pc_write:    1'b1,
    ifid_write:  1'b1,
    ifid_flush:  1'b1,
    idex_write:  1'b1,
    idex_flush:  1'b1,
    exmem_flush: 1'b1
  };

  // Load-use: hold PC and IF/ID, inject a bubble into ID/EX.
  localparam ctrl_t CtrlLoadUse = '{
    pc_write:    1'b0,
    ifid_write:  1'b0,
    ifid_flush:  1'b0,
    idex_write:  1'b1,
    idex_flush:  1'b1,
    exmem_flush: 1'b0
  };

  // Multi-cycle op occupying EX: hold everything upstream, bubble into MEM.
  localparam ctrl_t CtrlMulti = '{
    pc_write:    1'b0,
    ifid_write:  1'b0,
    ifid_flush:  1'b0,
    idex_write:  1'b0,
    idex_flush:  1'b0,
    exmem_flush: 1'b1
  };

  // A cycle is a stall cycle whenever the PC does not advance.
  function automatic logic is_stall(input ctrl_t c);
    return !c.pc_write;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard comparator: flags an ID instruction that reads the
// destination of a load currently in EX. Purely combinational.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [RegIdxW-1:0] ifid_rs,
  input  logic [RegIdxW-1:0] ifid_rt,
  input  logic               ifid_uses_rt,
  input  logic               idex_mem_read,
  input  logic [RegIdxW-1:0] idex_rt,
  output logic               lu_hazard
);

  logic rs_match;
  logic rt_match;

  // Writes to the zero register never create a dependency.
  always_comb begin
    rs_match  = (idex_rt == ifid_rs);
    rt_match  = ifid_uses_rt && (idex_rt == ifid_rt);
    lu_hazard = idex_mem_read && (idex_rt != ZeroReg) && (rs_match || rt_match);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline. Resolves taken branches,
// multi-cycle EX operations and load-use hazards (in that priority) and
// keeps a saturating count of cycles in which the PC was held.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MULTI_LAT = 4,
  parameter int unsigned CNT_W     = 4,
  parameter int unsigned PERF_W    = 16
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [RegIdxW-1:0] IFID_Rs,
  input  logic [RegIdxW-1:0] IFID_Rt,
  input  logic               IFID_UsesRt,
  input  logic               IDEX_MemRead,
  input  logic [RegIdxW-1:0] IDEX_Rt,
  input  logic               IDEX_Multi,
  input  logic               BranchTaken,
  output logic               PCWrite,
  output logic               IFIDWrite,
  output logic               IFIDFlush,
  output logic               IDEXWrite,
  output logic               IDEXFlush,
  output logic               EXMEMFlush,
  output logic               Busy,
  output logic [PERF_W-1:0]  StallCycles
);

  // A single-cycle "multi" op needs no stall at all.
  localparam bit MultiStalls = (MULTI_LAT >= 2);
  // Entry cycle is the first stall, so the countdown covers the remaining ones.
  localparam logic [CNT_W-1:0] CntLoad = MultiStalls ? CNT_W'(MULTI_LAT - 2) : '0;
  localparam logic [PERF_W-1:0] PerfMax = '1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PERF_W-1:0]  stall_q, stall_d;
  ctrl_t              ctrl;
  logic               lu_hazard;

  load_use_detect u_load_use_detect (
    .ifid_rs       (IFID_Rs),
    .ifid_rt       (IFID_Rt),
    .ifid_uses_rt  (IFID_UsesRt),
    .idex_mem_read (IDEX_MemRead),
    .idex_rt       (IDEX_Rt),
    .lu_hazard     (lu_hazard)
  );

  // Next-state and control outputs; reset and branch override every state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctrl    = CtrlDefault;
    if (Rst) begin
      ctrl    = CtrlReset;
      state_d = StRun;
      cnt_d   = '0;
    end else if (BranchTaken) begin
      // Squashes any multi-cycle op in EX along with the younger stages.
      ctrl    = CtrlBranch;
      state_d = StRun;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (IDEX_Multi) begin
            if (MultiStalls) begin
              ctrl    = CtrlMulti;
              cnt_d   = CntLoad;
              state_d = StMulti;
            end
          end else if (lu_hazard) begin
            ctrl    = CtrlLoadUse;
            state_d = StStallLu;
          end
        end
        StStallLu: begin
          // ID/EX now holds the bubble, so the hazard is gone by construction.
          state_d = StRun;
        end
        StMulti: begin
          if (cnt_q != '0) begin
            ctrl  = CtrlMulti;
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            // Release: result latches into EX/MEM, next op enters EX.
            state_d = StRun;
          end
        end
        default: begin
          state_d = StRun;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Saturating stall-cycle counter; reset cycles are not counted.
  always_comb begin
    stall_d = stall_q;
    if (!Rst && is_stall(ctrl) && (stall_q != PerfMax)) begin
      stall_d = stall_q + PERF_W'(1);
    end
  end

  // State, countdown and performance counter registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= StRun;
      cnt_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  // Output mapping.
  always_comb begin
    PCWrite     = ctrl.pc_write;
    IFIDWrite   = ctrl.ifid_write;
    IFIDFlush   = ctrl.ifid_flush;
    IDEXWrite   = ctrl.idex_write;
    IDEXFlush   = ctrl.idex_flush;
    EXMEMFlush  = ctrl.exmem_flush;
    Busy        = (state_q != StRun);
    StallCycles = stall_q;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipelined datapath: it drives the write-enable and flush controls of the PC, IF/ID, ID/EX and EX/MEM registers.
It resolves three hazard classes:
- load-use hazards (1-cycle bubble);
- multi-cycle EX operations (SAD accumulate unit, MULTI_LAT cycles in EX);
- taken branches resolved in MEM (flush of 3 younger stages).

Parameters:
MULTI_LAT, 4, total EX-stage occupancy of a multi-cycle op in cycles (legal range 1..2^CNT_W+1).
CNT_W, 4, width of the multi-cycle countdown counter.
PERF_W, 16, width of the saturating stall-cycle performance counter.

Ports:
Clk  in  1  clock; all state updates on rising edge
Rst  in  1  synchronous reset, active-high
IFID_Rs  in  5  source reg 1 of instruction in ID
IFID_Rt  in  5  source reg 2 of instruction in ID
IFID_UsesRt  in  1  ID instruction reads Rt as a source
IDEX_MemRead  in  1  instruction in EX is a load
IDEX_Rt  in  5  load destination register in EX
IDEX_Multi  in  1  instruction in EX is a multi-cycle op
BranchTaken  in  1  branch in MEM resolved taken
PCWrite  out  1  PC load enable
IFIDWrite  out  1  IF/ID load enable
IFIDFlush  out  1  IF/ID clear-to-bubble
IDEXWrite  out  1  ID/EX load enable
IDEXFlush  out  1  ID/EX control fields zeroed (bubble)
EXMEMFlush  out  1  EX/MEM control fields zeroed (bubble)
Busy  out  1  state != RUN
StallCycles  out  PERF_W  count of cycles with PCWrite=0, saturating

Behaviour:
- States: RUN, STALL_LU, MULTI. Registered: state, cnt[CNT_W], StallCycles. Control outputs are combinational from state, cnt and inputs.
- Reset (Rst=1):
  - During reset, outputs are PCWrite=0, IFIDWrite=0, IDEXWrite=0, IFIDFlush=1, IDEXFlush=1, EXMEMFlush=1.
  - Next state is RUN, cnt=0, StallCycles=0.
  - Reset mid-MULTI or mid-STALL_LU abandons the operation without exception.
- Default (no condition active): writes=1, flushes=0.
- lu_hazard = IDEX_MemRead && IDEX_Rt!=0 && (IDEX_Rt==IFID_Rs || (IFID_UsesRt && IDEX_Rt==IFID_Rt)).
- Priority in every state: BranchTaken > multi-cycle > load-use.
- BranchTaken (any state):
  - Outputs: PCWrite=1, IFIDWrite=1, IDEXWrite=1, IFIDFlush=1, IDEXFlush=1, EXMEMFlush=1.
  - Next state RUN, cnt<=0. A multi-cycle op in EX is squashed.
- RUN, IDEX_Multi=1, MULTI_LAT>=2:
  - Outputs: PCWrite=0, IFIDWrite=0, IDEXWrite=0, EXMEMFlush=1.
  - cnt<=MULTI_LAT-2, next MULTI.
- RUN, IDEX_Multi=1, MULTI_LAT=1: default outputs, no stall.
- RUN, lu_hazard (and not multi): PCWrite=0, IFIDWrite=0, IDEXFlush=1, next STALL_LU.
- STALL_LU:
  - Default outputs, next RUN (unconditional, 1 cycle).
  - lu_hazard is not re-evaluated, because ID/EX now holds a bubble.
- MULTI, cnt!=0: same stall outputs as MULTI entry, cnt<=cnt-1.
- MULTI, cnt==0 (release cycle): default outputs (result latched into EX/MEM, next op enters EX), next RUN.
- Stall length:
  - Multi-cycle op: exactly MULTI_LAT-1 stall cycles; result reaches EX/MEM at cycle MULTI_LAT.
  - Back-to-back multi ops: the second is detected in RUN on the cycle after release.
- StallCycles increments when PCWrite=0 and Rst=0; it holds at 2^PERF_W-1.
- Multi-cycle and load-use asserted together: multi wins; the load-use hazard is re-evaluated after release.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - state encoding constants (RUN=2'd0, STALL_LU=2'd1, MULTI=2'd2);
  - register index width (5);
  - zero-register index constant.
- One natural sub-module: load_use_detect (purely combinational lu_hazard comparator), reusable by a future forwarding unit.

Test Plan:
- Reset: hold Rst=1 for 2 cycles, then release. Required: during reset PCWrite=0 and all flushes=1; after release state=RUN, StallCycles=0, Busy=0.
- Load-use: IDEX_MemRead=1, IDEX_Rt=5, IFID_Rs=5. Required: one cycle with PCWrite=0, IDEXFlush=1, then STALL_LU with defaults, then RUN; StallCycles=1. The same test with IDEX_Rt=0 must produce no stall.
- Multi-cycle, MULTI_LAT=4: IDEX_Multi=1 in RUN. Required: 3 cycles with PCWrite=IDEXWrite=0 and EXMEMFlush=1, release in the 4th cycle, Busy high for cycles 2-4; StallCycles=3.
- Branch mid-MULTI: assert BranchTaken on the 2nd stall cycle. Required: all three flushes=1 and PCWrite=1 that cycle, state RUN next cycle, no further stall.
- Simultaneous events: in RUN, IDEX_Multi=1 and lu_hazard=1. Required: multi stall pattern. Repeat with BranchTaken=1 as well. Required: branch flush only, no stall.
- Saturation: PERF_W=4, force 20 stall cycles. Required: StallCycles=15 and holds.
